// File: rtl/data_mem_responder.sv
//==============================================================================
// Module   : data_mem_responder
// Purpose  : Single-cycle-latency data memory responder. Serves 32-bit loads
//            and byte-lane stores to a word RAM plus a two-register MMIO
//            window (GPIO read/write, free-running CYCLE counter read-only).
//            One request accepted per clock, no back-pressure; every sampled
//            request gets exactly one response strobe on the following cycle.
// Ports    : clock      - sole clock, rising edge
//            reset      - asynchronous, active-high
//            req_valid  - request present this cycle
//            req_write  - 1 = store, 0 = load
//            req_addr   - byte address
//            req_wdata  - store data, lane-aligned
//            req_wstrb  - byte-lane write enables
//            rsp_valid  - one-cycle response strobe
//            rsp_rdata  - load data (0 for stores, errors and idle cycles)
//            rsp_err    - request rejected (misaligned/unmapped/CYCLE write)
//            gpio_out   - GPIO register contents
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] gpio_out
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIMIT  = 33'(DEPTH_WORDS) << 2;
  localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'd4;

  // Merge store data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic          w_aligned;
  logic          w_hit_ram;
  logic          w_hit_gpio;
  logic          w_hit_cycle;
  logic          w_err;
  logic          w_ok;
  logic          w_ram_wr;
  logic          w_ram_rd;

  assign w_idx       = req_addr[AW+1:2];
  assign w_aligned   = (req_addr[1:0] == 2'b00);
  // RAM decode wins if the MMIO window were ever placed inside it.
  assign w_hit_ram   = ({1'b0, req_addr} < RAM_LIMIT);
  assign w_hit_gpio  = !w_hit_ram && (req_addr == MMIO_BASE);
  assign w_hit_cycle = !w_hit_ram && (req_addr == CYCLE_ADDR);
  assign w_err       = !w_aligned
                     || !(w_hit_ram || w_hit_gpio || w_hit_cycle)
                     || (w_hit_cycle && req_write);
  assign w_ok        = req_valid && !w_err;
  // RAM has no reset, so requests arriving while reset is high are gated here.
  assign w_ram_wr    = w_ok && req_write  && w_hit_ram && !reset;
  assign w_ram_rd    = w_ok && !req_write && w_hit_ram && !reset;

  // ---------------------------------------------------------------------------
  // Word RAM: synchronous write with lane enables, registered read.
  // A load sampled the edge after a store reads the already-updated word.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] ram_rd_q;

  always_ff @(posedge clock) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem_q[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
    if (w_ram_rd) ram_rd_q <= mem_q[w_idx];
  end

  // ---------------------------------------------------------------------------
  // MMIO registers and response pipeline stage
  // ---------------------------------------------------------------------------
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_ram_q,   rsp_ram_d;
  logic [31:0] rsp_data_q,  rsp_data_d;
  logic [31:0] gpio_q,      gpio_d;
  logic [31:0] cycle_q,     cycle_d;

  always_comb begin
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid && w_err;
    rsp_ram_d   = w_ok && !req_write && w_hit_ram;
    rsp_data_d  = 32'd0;
    if (w_ok && !req_write && !w_hit_ram) begin
      rsp_data_d = w_hit_gpio ? gpio_q : cycle_q;
    end
    gpio_d = gpio_q;
    if (w_ok && req_write && w_hit_gpio) begin
      gpio_d = lane_merge(gpio_q, req_wdata, req_wstrb);
    end
    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ram_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      gpio_q      <= 32'd0;
      cycle_q     <= 32'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ram_q   <= rsp_ram_d;
      rsp_data_q  <= rsp_data_d;
      gpio_q      <= gpio_d;
      cycle_q     <= cycle_d;
    end
  end

  // rsp_ram_q is only set for a valid RAM load, so idle cycles read back 0;
  // the RAM read register itself is never reset.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_ram_q ? ram_rd_q : rsp_data_q;
  assign gpio_out  = gpio_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none

module tb_data_mem_responder;

  localparam int unsigned DEPTH      = 1024;
  localparam logic [31:0] MBASE      = 32'h8000_0000;
  localparam logic [31:0] CYC        = MBASE + 32'd4;
  localparam logic [31:0] RAM_END    = 4 * DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] gpio_out;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE  (MBASE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .gpio_out (gpio_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference cycle count: value the CYCLE register should hold before each edge.
  logic [31:0] tb_cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cyc <= 32'd0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected response per rsp_valid strobe.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {rsp_err, rsp_rdata}, 33'd0 | 33'h1_0000_0000 ^ {rsp_err, rsp_rdata} ^ 33'h1_0000_0000 ^ 33'h1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {rsp_err, rsp_rdata}, {e.err, e.rdata});
      end
    end else begin
      check("idle_zero", {rsp_valid, rsp_err, rsp_rdata[30:0]}, 33'd0);
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_d, input logic exp_e,
                       input string name, input bit push);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    if (push) exp_q.push_back('{exp_d, exp_e, name});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_rsp_valid", {32'd0, rsp_valid}, 33'd0);
    check("reset_gpio", {1'b0, gpio_out}, 33'd0);
    @(negedge clock);
    reset = 1'b0;

    // CYCLE counts from 0 at the first edge after release.
    issue(0, CYC, 0, 0, 32'd0, 0, "cycle_edge0", 1);
    idle(4);
    issue(0, CYC, 0, 0, 32'd5, 0, "cycle_edge5", 1);

    // Full store then immediate load.
    issue(1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0, "st_full", 1);
    issue(0, 32'h10, 0, 0, 32'hDEAD_BEEF, 0, "ld_full", 1);
    // Single-lane store, then no-op store.
    issue(1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 0, "st_lane0", 1);
    issue(0, 32'h10, 0, 4'b1111, 32'hDEAD_BEAA, 0, "ld_lane0", 1);
    issue(1, 32'h10, 32'h1234_5678, 4'b0000, 0, 0, "st_nostrb", 1);
    issue(0, 32'h10, 0, 0, 32'hDEAD_BEAA, 0, "ld_nostrb", 1);

    // Error cases leave RAM untouched.
    issue(0, 32'h12, 0, 0, 0, 1, "ld_misaligned", 1);
    issue(0, RAM_END, 0, 0, 0, 1, "ld_unmapped", 1);
    issue(1, 32'h12, 32'h0, 4'b1111, 0, 1, "st_misaligned", 1);
    issue(1, RAM_END, 32'h0, 4'b1111, 0, 1, "st_unmapped", 1);
    issue(0, 32'h10, 0, 0, 32'hDEAD_BEAA, 0, "ld_after_err", 1);

    // Upper lanes and last RAM word.
    issue(1, 32'h14, 32'h1122_3344, 4'b1111, 0, 0, "st_w14", 1);
    issue(1, 32'h14, 32'hAABB_0000, 4'b1100, 0, 0, "st_w14_hi", 1);
    issue(0, 32'h14, 0, 0, 32'hAABB_3344, 0, "ld_w14", 1);
    issue(1, RAM_END - 4, 32'h5A5A_A5A5, 4'b1111, 0, 0, "st_last", 1);
    issue(0, RAM_END - 4, 0, 0, 32'h5A5A_A5A5, 0, "ld_last", 1);

    // GPIO.
    issue(1, MBASE, 32'h0000_00FF, 4'b1111, 0, 0, "st_gpio", 1);
    check("gpio_after_st", {1'b0, gpio_out}, {1'b0, 32'h0000_00FF});
    issue(1, MBASE, 32'h9955_7733, 4'b0100, 0, 0, "st_gpio_l2", 1);
    check("gpio_after_l2", {1'b0, gpio_out}, {1'b0, 32'h0055_00FF});
    issue(0, MBASE, 0, 0, 32'h0055_00FF, 0, "ld_gpio", 1);
    issue(1, CYC, 32'hFFFF_FFFF, 4'b1111, 0, 1, "st_cycle", 1);
    issue(0, CYC, 0, 0, tb_cyc, 0, "cycle_running", 1);
    issue(0, MBASE + 32'd8, 0, 0, 0, 1, "ld_mmio_unmapped", 1);
    issue(1, MBASE + 32'd2, 32'h1, 4'b1111, 0, 1, "st_mmio_misaligned", 1);
    check("gpio_after_errs", {1'b0, gpio_out}, {1'b0, 32'h0055_00FF});

    // Reset right after a load is sampled: its response must vanish.
    issue(1, 32'h20, 32'hCAFE_F00D, 4'b1111, 0, 0, "st_w20", 1);
    issue(0, 32'h20, 0, 0, 0, 0, "dropped", 0);
    reset = 1'b1;
    #1;
    check("rst_async_valid", {32'd0, rsp_valid}, 33'd0);
    check("rst_async_gpio", {1'b0, gpio_out}, 33'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = MBASE;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'b1111;
    repeat (2) @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'b0;
    reset = 1'b0;
    check("gpio_after_release", {1'b0, gpio_out}, 33'd0);

    // Back-to-back after release; RAM survives reset.
    issue(0, 32'h20, 0, 0, 32'hCAFE_F00D, 0, "ld_w20_post", 1);
    issue(0, CYC, 0, 0, 32'd1, 0, "cycle_post", 1);
    issue(0, MBASE, 0, 0, 32'd0, 0, "ld_gpio_post", 1);
    issue(0, 32'h10, 0, 0, 32'hDEAD_BEAA, 0, "ld_w10_post", 1);
    idle(3);
    check("drain", {1'b0, 32'(exp_q.size())}, 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, byte base address of the MMIO window.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, lane-aligned.
REQ-009 SHALL have port req_wstrb  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port rsp_valid  output  1  response strobe, one cycle per request.
REQ-011 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  request rejected, qualified by rsp_valid.
REQ-013 SHALL have port gpio_out  output  32  GPIO register contents.

Function
REQ-014 SHALL sample a request on each rising edge with req_valid=1; no back-pressure; one request per cycle sustained.
REQ-015 SHALL assert rsp_valid exactly one cycle after the sampling edge, for one cycle, with rsp_rdata/rsp_err valid in that cycle.
REQ-016 SHALL hold rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
REQ-017 SHALL decode RAM region as req_addr < 4*DEPTH_WORDS, indexed by req_addr[log2(DEPTH_WORDS)+1:2].
REQ-018 SHALL decode MMIO offsets MMIO_BASE+0x0 (GPIO, R/W) and MMIO_BASE+0x4 (CYCLE, read-only); all other addresses are unmapped.
REQ-019 SHALL flag rsp_err=1 for misaligned (req_addr[1:0]!=0), unmapped, or CYCLE-write requests, and then perform no state change and return rsp_rdata=0.
REQ-020 SHALL on a valid store write only lanes with req_wstrb[i]=1 at the sampling edge; req_wstrb=4'b0000 is a legal no-op store, rsp_err=0.
REQ-021 SHALL return on a valid load the full 32-bit word as stored at the sampling edge, ignoring req_wstrb.
REQ-022 SHALL return updated data for a load sampled one cycle after a store to the same word (no stale read).
REQ-023 SHALL increment CYCLE by 1 every clock, wrapping 32'hFFFF_FFFF to 0; a CYCLE load returns the count held at the sampling edge.
REQ-024 SHALL apply GPIO stores with the same lane rules as RAM and drive gpio_out from the register directly, updating the cycle after the sampling edge.

Reset
REQ-025 SHALL on reset force rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, CYCLE=0 immediately, independent of clock.
REQ-026 SHALL drop any response pending at reset assertion; no rsp_valid for it after reset release.
REQ-027 SHALL leave RAM contents unchanged by reset (undefined after power-up).
REQ-028 SHALL ignore requests on the edges while reset is high; the first edge with reset low samples normally.

Verification
REQ-029 SHALL: store 0xDEADBEEF strb 1111 to 0x10, load 0x10 next cycle -> rsp_valid 1 cycle later, rdata 0xDEADBEEF, err 0.
REQ-030 SHALL: after REQ-029, store 0x000000AA strb 0001 to 0x10, load 0x10 -> rdata 0xDEADBEAA; strb 0000 store -> unchanged, err 0.
REQ-031 SHALL: load 0x12 and load 4*DEPTH_WORDS -> err 1, rdata 0; prior contents of 0x10 unchanged.
REQ-032 SHALL: store 0x0000_00FF to MMIO_BASE -> gpio_out 0xFF next cycle; store to MMIO_BASE+4 -> err 1, CYCLE keeps counting.
REQ-033 SHALL: reset release, load MMIO_BASE+4 on edge k after release -> rdata k (counting from 0), two loads 5 cycles apart differ by 5.
REQ-034 SHALL: assert reset in the cycle after a load is sampled -> rsp_valid never rises for it, gpio_out 0, back-to-back requests after release each get exactly one response.
